// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, instruction-memory handshake and the IF/ID pipeline register.
// Also keeps completed-fetch and miss-cycle counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] PCF,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        MisalignErr,
  output logic [31:0] FetchCount,
  output logic [31:0] MissCycles
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {BOOT, RUN, WAIT} state_t;

  state_t          state;
  logic            fetch_done;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] redirect_pc;

  // A redirect in Execute kills whatever word memory presents this cycle.
  assign fetch_done  = imem_req & imem_ready & ~StallF & ~PCSrcE;
  assign pc_plus4    = PCF + XLEN'(4);
  assign redirect_pc = {PCTargetE[XLEN-1:2], 2'b00};
  assign imem_addr   = PCF;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= BOOT;
      imem_req    <= 1'b0;
      PCF         <= RESET_PC;
      InstrD      <= NOP_INSTR;
      PCD         <= '0;
      PCPlus4D    <= '0;
      ValidD      <= 1'b0;
      MisalignErr <= 1'b0;
      FetchCount  <= '0;
      MissCycles  <= '0;
    end else begin
      // Every non-reset cycle leaves the FSM in RUN or WAIT, both of which request.
      imem_req <= 1'b1;

      case (state)
        BOOT:    state <= RUN;
        RUN:     if (!imem_ready && !StallF) state <= WAIT;
        WAIT:    if (imem_ready || PCSrcE)   state <= RUN;
        default: state <= BOOT;
      endcase

      if (PCSrcE) begin
        PCF <= redirect_pc;
      end else if (fetch_done) begin
        PCF <= pc_plus4;
      end

      MisalignErr <= PCSrcE & (PCTargetE[1:0] != 2'b00);

      if (FlushD) begin
        InstrD   <= NOP_INSTR;
        PCD      <= '0;
        PCPlus4D <= '0;
        ValidD   <= 1'b0;
      end else if (StallD) begin
        InstrD   <= InstrD;
      end else if (fetch_done) begin
        InstrD   <= imem_rdata;
        PCD      <= PCF;
        PCPlus4D <= pc_plus4;
        ValidD   <= 1'b1;
      end else begin
        InstrD   <= NOP_INSTR;
        PCD      <= '0;
        PCPlus4D <= '0;
        ValidD   <= 1'b0;
      end

      if (fetch_done && FetchCount != CNT_MAX) begin
        FetchCount <= FetchCount + XLEN'(1);
      end
      if (state == WAIT && MissCycles != CNT_MAX) begin
        MissCycles <= MissCycles + XLEN'(1);
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: two instances (default and wrap-around reset PC) checked
// every cycle against a cycle-level behavioural model built from the fetch rules.
module tb_fetch_unit;

  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] RPC1  = 32'hFFFF_FFFC;
  localparam int unsigned NRAND = 3000;

  logic        clk = 1'b0;
  logic        reset;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        StallF, StallD, FlushD;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  logic        req0, valid0, mis0, req1, valid1, mis1;
  logic [31:0] addr0, pcf0, instr0, pcd0, pcp40, fc0, mc0;
  logic [31:0] addr1, pcf1, instr1, pcd1, pcp41, fc1, mc1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit          booting;
    bit          waiting;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic [31:0] pcp4;
    bit          valid;
    bit          mis;
    logic [31:0] fc;
    logic [31:0] mc;
  } model_t;

  model_t m0, m1;

  always #5 clk = ~clk;

  fetch_unit dut0 (
    .clk(clk), .reset(reset), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .imem_req(req0), .imem_addr(addr0), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .PCF(pcf0), .InstrD(instr0), .PCD(pcd0), .PCPlus4D(pcp40), .ValidD(valid0),
    .MisalignErr(mis0), .FetchCount(fc0), .MissCycles(mc0)
  );

  fetch_unit #(.RESET_PC(RPC1)) dut1 (
    .clk(clk), .reset(reset), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .imem_req(req1), .imem_addr(addr1), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .PCF(pcf1), .InstrD(instr1), .PCD(pcd1), .PCPlus4D(pcp41), .ValidD(valid1),
    .MisalignErr(mis1), .FetchCount(fc1), .MissCycles(mc1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of the fetch rules applied to the model, using the inputs present at the edge.
  function automatic model_t step(input model_t m, input logic [31:0] rpc);
    model_t n = m;
    bit done;
    if (reset) begin
      n.booting = 1; n.waiting = 0; n.pc = rpc;
      n.instr = NOP; n.pcd = 0; n.pcp4 = 0; n.valid = 0; n.mis = 0; n.fc = 0; n.mc = 0;
      return n;
    end
    done  = !m.booting && imem_ready && !StallF && !PCSrcE;
    n.mis = PCSrcE && (PCTargetE % 4 != 0);
    if (PCSrcE)    n.pc = PCTargetE - (PCTargetE % 4);
    else if (done) n.pc = m.pc + 32'd4;
    if (FlushD || (!StallD && !done)) begin
      n.instr = NOP; n.pcd = 0; n.pcp4 = 0; n.valid = 0;
    end else if (!StallD) begin
      n.instr = imem_rdata; n.pcd = m.pc; n.pcp4 = m.pc + 32'd4; n.valid = 1;
    end
    if (done && m.fc != 32'hFFFF_FFFF)      n.fc = m.fc + 1;
    if (m.waiting && m.mc != 32'hFFFF_FFFF) n.mc = m.mc + 1;
    if (m.booting)      n.booting = 0;
    else if (!m.waiting) n.waiting = !imem_ready && !StallF;
    else                 n.waiting = !(imem_ready || PCSrcE);
    return n;
  endfunction

  task automatic check_dut(input string p, input model_t m,
                           input logic req, input logic [31:0] addr, input logic [31:0] pcf,
                           input logic [31:0] instr, input logic [31:0] pcd, input logic [31:0] pcp4,
                           input logic valid, input logic mis, input logic [31:0] fc,
                           input logic [31:0] mc);
    check({p, ".imem_req"}, 32'(req), 32'(!m.booting));
    check({p, ".imem_addr"}, addr, m.pc);
    check({p, ".PCF"}, pcf, m.pc);
    check({p, ".ValidD"}, 32'(valid), 32'(m.valid));
    check({p, ".InstrD"}, instr, m.instr);
    check({p, ".PCD"}, pcd, m.pcd);
    check({p, ".PCPlus4D"}, pcp4, m.pcp4);
    check({p, ".MisalignErr"}, 32'(mis), 32'(m.mis));
    check({p, ".FetchCount"}, fc, m.fc);
    check({p, ".MissCycles"}, mc, m.mc);
  endtask

  task automatic tick();
    @(posedge clk);
    m0 = step(m0, 32'h0);
    m1 = step(m1, RPC1);
    #1;
    check_dut("u0", m0, req0, addr0, pcf0, instr0, pcd0, pcp40, valid0, mis0, fc0, mc0);
    check_dut("u1", m1, req1, addr1, pcf1, instr1, pcd1, pcp41, valid1, mis1, fc1, mc1);
  endtask

  task automatic drive(input bit rst, input bit src, input logic [31:0] tgt,
                       input bit sf, input bit sd, input bit fl, input bit rdy);
    reset = rst; PCSrcE = src; PCTargetE = tgt;
    StallF = sf; StallD = sd; FlushD = fl; imem_ready = rdy;
    imem_rdata = $urandom;
  endtask

  initial begin
    m0 = '{default: 0};
    m1 = '{default: 0};
    drive(1, 0, 0, 0, 0, 0, 1);
    repeat (2) tick();

    // Straight-line fetch from reset; the second instance wraps FFFFFFFC -> 0.
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1);
      tick();
    end
    check("fc_after_straight", fc0, 32'd5);

    // Memory misses, then a redirect out of WAIT, then a misaligned redirect.
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    drive(0, 1, 32'h0000_0200, 0, 0, 0, 0);
    tick();
    check("redirect_pc", pcf0, 32'h0000_0200);
    drive(0, 1, 32'h0000_0103, 0, 0, 0, 1);
    tick();
    check("misalign_pc", pcf0, 32'h0000_0100);
    check("misalign_pulse", 32'(mis0), 32'd1);

    // Full stall for two cycles, then flush Decode.
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 1, 1, 0, 1);
      tick();
    end
    drive(0, 0, 0, 0, 0, 1, 1);
    tick();
    check("flush_instr", instr0, NOP);

    // Reset while waiting on memory.
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    drive(1, 0, 0, 0, 0, 0, 0);
    tick();
    check("reset_mid_wait_pc", pcf1, RPC1);

    // Random traffic; StallD only with StallF so no completed fetch is ever dropped.
    for (int unsigned i = 0; i < NRAND; i++) begin
      bit sf, sd;
      logic [31:0] tgt;
      sf  = ($urandom_range(99) < 15);
      sd  = sf && ($urandom_range(1) == 1);
      tgt = $urandom;
      if ($urandom_range(1) == 1) tgt[1:0] = 2'b00;
      drive($urandom_range(99) < 2, $urandom_range(99) < 10, tgt,
            sf, sd, $urandom_range(99) < 10, $urandom_range(99) < 70);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
